// File: rtl/sd_cmd_serial_engine.sv
// sd_cmd_serial_engine
//   Bit-serial SD CMD-line engine in the SD card clock domain. Accepts a
//   40-bit command frame and a settings word from the command master. It
//   appends CRC7 and the stop bit, shifts the 48-bit frame out on CMD, then
//   receives and CRC-checks the card response. It hands the response and a
//   status word back to the master over a second req/ack handshake.
//
// Ports
//   CLK_PAD_IO  in   SD card clock, rising edge
//   RST_PAD_I   in   asynchronous active-high reset
//   cmd_dat_i   in   CMD line input
//   cmd_out_o   out  CMD line output value
//   cmd_oe_o    out  CMD line output enable
//   cmd_in      in   [39:0] command frame {2'b01, index, arg}
//   setting_in  in   [15:0] [10:8] turnaround, [6:0] response size code
//   req_in      in   master command strobe (asynchronous, 2-flop synced)
//   ack_out     out  engine idle / ready for a command
//   req_out     out  response and status valid for the master
//   ack_in      in   master acknowledge of req_out (2-flop synced)
//   cmd_out     out  [39:0] first 40 bits of the captured response
//   status      out  [6] response available, [5] CRC valid, [0] busy
//   go_idle_i   in   abort to IDLE (ignored during INIT)
//
// State       | meaning
// ------------+------------------------------------------------------------
// S_INIT      | power-up: drive CMD=1 for INIT_CYCLES clocks
// S_IDLE      | line released, ack_out high, waiting for the synced request
// S_LOAD      | one clock between capture and the first transmitted bit
// S_WRITE     | 48 bits out MSB first: command, CRC7, stop bit
// S_TURN      | line released for turnaround+1 clocks
// S_READ_WAIT | waiting for the response start bit
// S_READ      | receiving the rest of the response
// S_REPORT    | response and status just presented to the master
// S_HS_WAIT   | holding results until ack_in rises and falls again

module sd_cmd_serial_engine #(
  parameter int         INIT_CYCLES = 80,
  parameter logic [6:0] RSP_SHORT   = 7'd40,
  parameter logic [6:0] RSP_LONG    = 7'd127
) (
  input  logic        CLK_PAD_IO,
  input  logic        RST_PAD_I,
  input  logic        cmd_dat_i,
  output logic        cmd_out_o,
  output logic        cmd_oe_o,
  input  logic [39:0] cmd_in,
  input  logic [15:0] setting_in,
  input  logic        req_in,
  output logic        ack_out,
  output logic        req_out,
  input  logic        ack_in,
  output logic [39:0] cmd_out,
  output logic [15:0] status,
  input  logic        go_idle_i
);

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_LOAD, S_WRITE, S_TURN,
    S_READ_WAIT, S_READ, S_REPORT, S_HS_WAIT
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [6:0]  crc, crc_nxt;
  logic [39:0] tx_sr, tx_sr_nxt;
  logic [2:0]  turn, turn_nxt;
  logic [6:0]  rsp_code, rsp_code_nxt;
  logic [39:0] rsp_frame, rsp_frame_nxt;
  logic        crc_ok, crc_ok_nxt;
  logic        busy, busy_nxt;
  logic        rsp_avail, rsp_avail_nxt;
  logic        crc_valid, crc_valid_nxt;
  logic        line_oe, line_oe_nxt;
  logic        line_out, line_out_nxt;
  logic        ack_r, ack_nxt;
  logic        req_r, req_nxt;

  logic        req_s1, req_s2, ack_s1, ack_s2;
  logic        rsp_long;
  logic [7:0]  data_floor;

  // Read-side request and write-enable bits are not needed on the CMD line;
  // any non-zero, non-long size code (RSP_SHORT included) is a short response.
  logic unused_cfg;
  assign unused_cfg = ^{setting_in[15:11], setting_in[7], RSP_SHORT};

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  assign rsp_long   = (rsp_code == RSP_LONG);
  // While cnt is above this floor the received bit still belongs to the first
  // 40 frame bits (39 after the start bit).
  assign data_floor = rsp_long ? 8'd96 : 8'd8;

  always_ff @(posedge CLK_PAD_IO or posedge RST_PAD_I) begin
    if (RST_PAD_I) begin
      req_s1 <= 1'b0;
      req_s2 <= 1'b0;
      ack_s1 <= 1'b0;
      ack_s2 <= 1'b0;
    end else begin
      req_s1 <= req_in;
      req_s2 <= req_s1;
      ack_s1 <= ack_in;
      ack_s2 <= ack_s1;
    end
  end

  always_ff @(posedge CLK_PAD_IO or posedge RST_PAD_I) begin
    if (RST_PAD_I) begin
      state     <= S_INIT;
      cnt       <= 8'(INIT_CYCLES);
      crc       <= 7'd0;
      tx_sr     <= 40'd0;
      turn      <= 3'd0;
      rsp_code  <= 7'd0;
      rsp_frame <= 40'd0;
      crc_ok    <= 1'b0;
      busy      <= 1'b0;
      rsp_avail <= 1'b0;
      crc_valid <= 1'b0;
      line_oe   <= 1'b0;
      line_out  <= 1'b1;
      ack_r     <= 1'b0;
      req_r     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      crc       <= crc_nxt;
      tx_sr     <= tx_sr_nxt;
      turn      <= turn_nxt;
      rsp_code  <= rsp_code_nxt;
      rsp_frame <= rsp_frame_nxt;
      crc_ok    <= crc_ok_nxt;
      busy      <= busy_nxt;
      rsp_avail <= rsp_avail_nxt;
      crc_valid <= crc_valid_nxt;
      line_oe   <= line_oe_nxt;
      line_out  <= line_out_nxt;
      ack_r     <= ack_nxt;
      req_r     <= req_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    crc_nxt       = crc;
    tx_sr_nxt     = tx_sr;
    turn_nxt      = turn;
    rsp_code_nxt  = rsp_code;
    rsp_frame_nxt = rsp_frame;
    crc_ok_nxt    = crc_ok;
    busy_nxt      = busy;
    rsp_avail_nxt = rsp_avail;
    crc_valid_nxt = crc_valid;
    line_oe_nxt   = line_oe;
    line_out_nxt  = line_out;
    ack_nxt       = ack_r;
    req_nxt       = req_r;

    if (go_idle_i && state != S_INIT) begin
      state_nxt     = S_IDLE;
      cnt_nxt       = 8'd0;
      crc_nxt       = 7'd0;
      tx_sr_nxt     = 40'd0;
      turn_nxt      = 3'd0;
      rsp_code_nxt  = 7'd0;
      busy_nxt      = 1'b0;
      rsp_avail_nxt = 1'b0;
      line_oe_nxt   = 1'b0;
      line_out_nxt  = 1'b1;
      ack_nxt       = 1'b1;
      req_nxt       = 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          line_oe_nxt  = 1'b1;
          line_out_nxt = 1'b1;
          if (cnt == 8'd0) begin
            line_oe_nxt = 1'b0;
            ack_nxt     = 1'b1;
            state_nxt   = S_IDLE;
          end else begin
            cnt_nxt = cnt - 8'd1;
          end
        end
        S_IDLE: begin
          line_oe_nxt  = 1'b0;
          line_out_nxt = 1'b1;
          ack_nxt      = 1'b1;
          busy_nxt     = 1'b0;
          if (req_s2) begin
            tx_sr_nxt    = cmd_in;
            turn_nxt     = setting_in[10:8];
            rsp_code_nxt = setting_in[6:0];
            crc_nxt      = 7'd0;
            ack_nxt      = 1'b0;
            busy_nxt     = 1'b1;
            state_nxt    = S_LOAD;
          end
        end
        S_LOAD: begin
          cnt_nxt   = 8'd47;
          state_nxt = S_WRITE;
        end
        S_WRITE: begin
          // cnt is the frame bit index being driven this clock.
          line_oe_nxt = 1'b1;
          if (cnt > 8'd7) begin
            line_out_nxt = tx_sr[39];
            tx_sr_nxt    = {tx_sr[38:0], 1'b0};
            crc_nxt      = crc7_step(crc, tx_sr[39]);
          end else if (cnt != 8'd0) begin
            line_out_nxt = crc[6];
            crc_nxt      = {crc[5:0], 1'b0};
          end else begin
            line_out_nxt = 1'b1;
          end
          if (cnt == 8'd0) begin
            cnt_nxt   = {5'd0, turn};
            state_nxt = S_TURN;
          end else begin
            cnt_nxt = cnt - 8'd1;
          end
        end
        S_TURN: begin
          line_oe_nxt  = 1'b0;
          line_out_nxt = 1'b1;
          if (cnt == 8'd0) begin
            crc_nxt    = 7'd0;
            crc_ok_nxt = 1'b1;
            if (rsp_code == 7'd0) begin
              rsp_avail_nxt = 1'b1;
              crc_valid_nxt = 1'b1;
              req_nxt       = 1'b1;
              state_nxt     = S_REPORT;
            end else begin
              state_nxt = S_READ_WAIT;
            end
          end else begin
            cnt_nxt = cnt - 8'd1;
          end
        end
        S_READ_WAIT: begin
          if (!cmd_dat_i) begin
            rsp_frame_nxt = {rsp_frame[38:0], 1'b0};
            crc_nxt       = crc7_step(crc, 1'b0);
            cnt_nxt       = rsp_long ? 8'd135 : 8'd47;
            state_nxt     = S_READ;
          end
        end
        S_READ: begin
          // cnt counts the bits still to come, this one included.
          if (cnt > data_floor) begin
            rsp_frame_nxt = {rsp_frame[38:0], cmd_dat_i};
            crc_nxt       = crc7_step(crc, cmd_dat_i);
          end else if (!rsp_long && cnt > 8'd1) begin
            if (cmd_dat_i != crc[6]) crc_ok_nxt = 1'b0;
            crc_nxt = {crc[5:0], 1'b0};
          end
          if (cnt == 8'd1) begin
            rsp_avail_nxt = 1'b1;
            crc_valid_nxt = crc_ok_nxt;
            req_nxt       = 1'b1;
            state_nxt     = S_REPORT;
          end else begin
            cnt_nxt = cnt - 8'd1;
          end
        end
        S_REPORT: begin
          state_nxt = S_HS_WAIT;
        end
        S_HS_WAIT: begin
          if (req_r && ack_s2) begin
            req_nxt = 1'b0;
          end else if (!req_r && !ack_s2) begin
            ack_nxt       = 1'b1;
            busy_nxt      = 1'b0;
            rsp_avail_nxt = 1'b0;
            state_nxt     = S_IDLE;
          end
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign cmd_out_o = line_out;
  assign cmd_oe_o  = line_oe;
  assign ack_out   = ack_r;
  assign req_out   = req_r;
  assign cmd_out   = rsp_frame;
  assign status    = {9'd0, rsp_avail, crc_valid, 4'd0, busy};

endmodule

// File: tb/tb_sd_cmd_serial_engine.sv
// Testbench for sd_cmd_serial_engine: drives commands as the master, plays
// the card on the CMD line, and checks frames, status and timing against a
// reference built from CRC7 long division and whole-frame vectors.

module tb_sd_cmd_serial_engine;

  logic        clk, rst;
  logic        cmd_dat_i, cmd_out_o, cmd_oe_o;
  logic [39:0] cmd_in, cmd_out;
  logic [15:0] setting_in, status;
  logic        req_in, ack_out, req_out, ack_in, go_idle_i;

  int          n_checks, n_fail;
  logic [39:0] exp_cmd_out;

  sd_cmd_serial_engine dut (
    .CLK_PAD_IO (clk),
    .RST_PAD_I  (rst),
    .cmd_dat_i  (cmd_dat_i),
    .cmd_out_o  (cmd_out_o),
    .cmd_oe_o   (cmd_oe_o),
    .cmd_in     (cmd_in),
    .setting_in (setting_in),
    .req_in     (req_in),
    .ack_out    (ack_out),
    .req_out    (req_out),
    .ack_in     (ack_in),
    .cmd_out    (cmd_out),
    .status     (status),
    .go_idle_i  (go_idle_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // CRC7 (x^7 + x^3 + 1) as the remainder of polynomial long division.
  function automatic logic [6:0] crc7_ref(input logic [39:0] msg);
    logic [46:0] r, p;
    r = {msg, 7'd0};
    for (int i = 46; i >= 7; i--) begin
      if (r[i]) begin
        p = 47'h89 << (i - 7);
        r = r ^ p;
      end
    end
    return r[6:0];
  endfunction

  // sel: 0 ack_out, 1 req_out, 2 cmd_oe_o
  task automatic wait_for(input int sel, input logic val, input string tag, input int budget);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < budget && !hit; k++) begin
      @(posedge clk); #1;
      case (sel)
        0:       hit = (ack_out == val);
        1:       hit = (req_out == val);
        default: hit = (cmd_oe_o == val);
      endcase
    end
    chk(tag, hit, 1'b1);
  endtask

  task automatic reset_and_init();
    int  cnt;
    bit  done;
    rst = 1'b1; req_in = 1'b0; ack_in = 1'b0; go_idle_i = 1'b0;
    cmd_dat_i = 1'b1; cmd_in = '0; setting_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_oe", cmd_oe_o, 0);
    chk("rst_out", cmd_out_o, 1);
    chk("rst_ack", ack_out, 0);
    chk("rst_req", req_out, 0);
    chk("rst_cmd_out", cmd_out, 0);
    chk("rst_status", status, 0);
    exp_cmd_out = '0;
    rst = 1'b0;
    cnt = 0; done = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(posedge clk); #1;
      if (cmd_oe_o && cmd_out_o) cnt++;
      else done = 1;
    end
    chk("init_cycles", cnt, 80);
    chk("init_ack", ack_out, 1);
  endtask

  // abort: 0 none, 1 go_idle pulse after bit 20, 2 reset after bit 20
  task automatic run_txn(input logic [39:0] cmd, input logic [2:0] turn,
                         input logic [6:0] size, input logic [39:0] rsp40,
                         input bit flip, input int abort);
    logic [15:0]  setw, exp_status;
    logic [47:0]  exp_frame, got_frame;
    logic [135:0] rb;
    logic [95:0]  fill;
    logic [6:0]   rcrc;
    bit           oe_ok, is_long;
    int           n, d;

    setw      = {3'b000, 2'($urandom), turn, 1'b1, size};
    exp_frame = {cmd, crc7_ref(cmd), 1'b1};
    got_frame = '0;
    @(negedge clk);
    cmd_in = cmd; setting_in = setw; req_in = 1'b1;
    wait_for(0, 1'b0, "accept", 10);
    req_in = 1'b0;
    wait_for(2, 1'b1, "frame_start", 10);
    got_frame[47] = cmd_out_o;
    oe_ok = 1;
    for (int i = 46; i >= 0; i--) begin
      @(posedge clk); #1;
      got_frame[i] = cmd_out_o;
      if (!cmd_oe_o) oe_ok = 0;
      if (abort != 0 && i == 20) begin
        chk("abort_partial", got_frame[47:20], exp_frame[47:20]);
        if (abort == 1) begin
          @(negedge clk); go_idle_i = 1'b1;
          @(posedge clk); #1;
          chk("go_idle_oe", cmd_oe_o, 0);
          chk("go_idle_ack", ack_out, 1);
          chk("go_idle_req", req_out, 0);
          chk("go_idle_status", status & 16'h0041, 0);
          @(negedge clk); go_idle_i = 1'b0;
        end else begin
          @(negedge clk); rst = 1'b1; #1;
          chk("rst_async_oe", cmd_oe_o, 0);
          reset_and_init();
        end
        return;
      end
    end
    chk("oe_during_frame", oe_ok, 1);
    chk("cmd_frame", got_frame, exp_frame);
    @(posedge clk); #1;
    chk("oe_release", cmd_oe_o, 0);

    if (size == 7'd0) begin
      wait_for(1, 1'b1, "rsp_none_req", 12);
      exp_status = 16'h0061;
    end else begin
      is_long = (size == 7'd127);
      rcrc = crc7_ref(rsp40);
      if (flip) rcrc = rcrc ^ (7'd1 << $urandom_range(0, 6));
      fill = {$urandom, $urandom, $urandom};
      if (is_long) rb = {rsp40, fill[94:0], 1'b1};
      else         rb = {rsp40, rcrc, 1'b1, 88'd0};
      n = is_long ? 136 : 48;
      d = $urandom_range(0, 4);
      repeat (int'(turn) + d) @(posedge clk);
      for (int i = 0; i < n; i++) begin
        @(negedge clk); cmd_dat_i = rb[135 - i];
        @(posedge clk); #1;
        if (i == n - 2) chk("req_early", req_out, 0);
        if (i == n - 1) chk("req_latency", req_out, 1);
      end
      cmd_dat_i = 1'b1;
      exp_cmd_out = rsp40;
      exp_status  = {9'd0, 1'b1, (is_long || !flip), 4'd0, 1'b1};
    end
    chk("cmd_out", cmd_out, exp_cmd_out);
    chk("status", status, exp_status);
    ack_in = 1'b1;
    wait_for(1, 1'b0, "req_drop", 10);
    chk("cmd_out_hold", cmd_out, exp_cmd_out);
    chk("status_hold", status, exp_status);
    ack_in = 1'b0;
    wait_for(0, 1'b1, "back_idle", 10);
    chk("status_idle", status & 16'h0041, 0);
  endtask

  initial begin
    logic [6:0]  size;
    logic [39:0] cmd, rsp;
    logic [6:0]  crc0;
    logic [39:0] cmd0;
    n_checks = 0; n_fail = 0;

    reset_and_init();

    cmd0 = {2'b01, 6'd0, 32'd0};
    crc0 = crc7_ref(cmd0);
    chk("cmd0_reference", {cmd0, crc0, 1'b1}, 48'h400000000095);
    run_txn(cmd0, 3'd2, 7'd0, 40'd0, 0, 0);

    run_txn({2'b01, 6'd17, 32'd0}, 3'd1, 7'd40, 40'h1100000900, 0, 0);
    run_txn({2'b01, 6'd17, 32'd0}, 3'd0, 7'd40, 40'h1100000900, 1, 0);
    run_txn({2'b01, 6'd2, 32'd0}, 3'd3, 7'd127, 40'h3F1234ABCD, 0, 0);

    run_txn({2'b01, 6'd17, 32'h0000_1234}, 3'd1, 7'd40, 40'h1100000900, 0, 1);
    run_txn({2'b01, 6'd17, 32'h0000_1234}, 3'd1, 7'd40, 40'h1100000A00, 0, 0);

    for (int t = 0; t < 10; t++) begin
      case ($urandom_range(0, 3))
        0:       size = 7'd0;
        1:       size = 7'd40;
        2:       size = 7'd127;
        default: size = 7'($urandom_range(1, 126));
      endcase
      cmd = {2'b01, 6'($urandom), $urandom};
      rsp = {2'b00, 6'($urandom), $urandom};
      run_txn(cmd, 3'($urandom), size, rsp, bit'($urandom_range(0, 1)), 0);
    end

    run_txn({2'b01, 6'd8, 32'h0000_01AA}, 3'd2, 7'd40, 40'h08000001AA, 0, 2);
    run_txn({2'b01, 6'd8, 32'h0000_01AA}, 3'd2, 7'd40, 40'h08000001AA, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
